memory_module: RTL and testbench

- MEM stage of the pipelined LC-3b, directly downstream of the execute stage.
- Takes the ALU result as the data address, plus store data, IR, PC and control, and runs LDR/STR/LDB/STB against the data cache with a request/response handshake.
- Stalls upstream while an access is outstanding.
- Registers its results into the MEM/WB boundary for writeback.

---
 rtl/memory_module.sv | 195 +++++++++++++++++++
 tb/tb_memory_module.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_module.sv
// MEM stage of the pipelined LC-3b: runs LDR/STR/LDB/STB against the data cache and registers MEM/WB.
// Optional build macro MEM_MISALIGN_TRAP_EN adds misalign_out and traps odd word accesses.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | accepting instructions; non-memory ops retire in one cycle
// ACCESS | cache request held from captured registers until dmem_resp
module memory_module #(
    parameter int CTRL_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              flush,
    input  logic [15:0]       alu_in,
    input  logic [15:0]       store_data_in,
    input  logic [15:0]       ir_in,
    input  logic [15:0]       pc_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_byte,
    output logic              stall,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [15:0]       dmem_address,
    output logic [15:0]       dmem_wdata,
    output logic [1:0]        dmem_byte_enable,
    input  logic [15:0]       dmem_rdata,
    input  logic              dmem_resp,
    output logic              valid_out,
    output logic [15:0]       result_out,
    output logic [15:0]       alu_out,
    output logic [15:0]       ir_out,
    output logic [15:0]       pc_out,
    output logic [CTRL_W-1:0] ctrl_out
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign_out
`endif
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]        state;
    logic              live;
    logic              mem_op;
    logic              trap;
    logic              accept_mem;
    logic              accept_alu;
    logic              done;

    logic              acc_read;
    logic              acc_byte;
    logic              acc_bsel;
    logic [15:0]       acc_alu;
    logic [15:0]       acc_addr;
    logic [15:0]       acc_wdata;
    logic [1:0]        acc_be;
    logic [15:0]       acc_ir;
    logic [15:0]       acc_pc;
    logic [CTRL_W-1:0] acc_ctrl;

    logic [15:0]       cap_wdata;
    logic [1:0]        cap_be;

    function automatic logic [15:0] format_load(input logic [15:0] rdata,
                                                input logic        byte_op,
                                                input logic        bsel);
        logic [7:0] b;
        b = bsel ? rdata[15:8] : rdata[7:0];
        return byte_op ? {{8{b[7]}}, b} : rdata;
    endfunction

    assign live   = valid_in & ~flush;
    assign mem_op = mem_read | mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = live & mem_op & ~mem_byte & alu_in[0];
`else
    assign trap = 1'b0;
`endif

    assign accept_mem = (state == IDLE) & live & mem_op & ~trap;
    assign accept_alu = (state == IDLE) & live & (~mem_op | trap);
    assign done       = (state == ACCESS) & dmem_resp;

    assign stall = accept_mem | ((state == ACCESS) & ~dmem_resp);

    // A simultaneous read/write is treated as a read, so byte enables follow the read rule.
    always_comb begin
        cap_wdata = mem_byte ? {store_data_in[7:0], store_data_in[7:0]} : store_data_in;
        cap_be    = 2'b11;
        if (!mem_read && mem_byte) begin
            cap_be = alu_in[0] ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc_read  <= 1'b0;
            acc_byte  <= 1'b0;
            acc_bsel  <= 1'b0;
            acc_alu   <= '0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            acc_be    <= '0;
            acc_ir    <= '0;
            acc_pc    <= '0;
            acc_ctrl  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_mem) begin
                        state     <= ACCESS;
                        acc_read  <= mem_read;
                        acc_byte  <= mem_byte;
                        acc_bsel  <= alu_in[0];
                        acc_alu   <= alu_in;
                        acc_addr  <= {alu_in[15:1], 1'b0};
                        acc_wdata <= cap_wdata;
                        acc_be    <= cap_be;
                        acc_ir    <= ir_in;
                        acc_pc    <= pc_in;
                        acc_ctrl  <= ctrl_in;
                    end
                end
                ACCESS: begin
                    if (dmem_resp) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = '0;
        if (state == ACCESS) begin
            dmem_read        = acc_read;
            dmem_write       = ~acc_read;
            dmem_address     = acc_addr;
            dmem_wdata       = acc_wdata;
            dmem_byte_enable = acc_be;
        end
    end

    // MEM/WB boundary: fields other than valid_out hold unless an instruction retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out  <= 1'b0;
            result_out <= '0;
            alu_out    <= '0;
            ir_out     <= '0;
            pc_out     <= '0;
            ctrl_out   <= '0;
        end else if (accept_alu) begin
            valid_out  <= 1'b1;
            result_out <= alu_in;
            alu_out    <= alu_in;
            ir_out     <= ir_in;
            pc_out     <= pc_in;
            ctrl_out   <= ctrl_in;
        end else if (done) begin
            valid_out  <= 1'b1;
            result_out <= acc_read ? format_load(dmem_rdata, acc_byte, acc_bsel) : acc_alu;
            alu_out    <= acc_alu;
            ir_out     <= acc_ir;
            pc_out     <= acc_pc;
            ctrl_out   <= acc_ctrl;
        end else begin
            valid_out  <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_out <= 1'b0;
        end else if (accept_alu) begin
            misalign_out <= trap;
        end else if (done) begin
            misalign_out <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_memory_module.sv
// Self-checking bench for memory_module: vector table driven through a scoreboard plus corner sequences.
module tb_memory_module;

    localparam int CTRL_W = 24;

    logic              clk;
    logic              rst;
    logic              valid_in;
    logic              flush;
    logic [15:0]       alu_in;
    logic [15:0]       store_data_in;
    logic [15:0]       ir_in;
    logic [15:0]       pc_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic              mem_read;
    logic              mem_write;
    logic              mem_byte;
    logic              stall;
    logic              dmem_read;
    logic              dmem_write;
    logic [15:0]       dmem_address;
    logic [15:0]       dmem_wdata;
    logic [1:0]        dmem_byte_enable;
    logic [15:0]       dmem_rdata;
    logic              dmem_resp;
    logic              valid_out;
    logic [15:0]       result_out;
    logic [15:0]       alu_out;
    logic [15:0]       ir_out;
    logic [15:0]       pc_out;
    logic [CTRL_W-1:0] ctrl_out;

    memory_module #(.CTRL_W(CTRL_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (valid_in),
        .flush            (flush),
        .alu_in           (alu_in),
        .store_data_in    (store_data_in),
        .ir_in            (ir_in),
        .pc_in            (pc_in),
        .ctrl_in          (ctrl_in),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_byte         (mem_byte),
        .stall            (stall),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .valid_out        (valid_out),
        .result_out       (result_out),
        .alu_out          (alu_out),
        .ir_out           (ir_out),
        .pc_out           (pc_out),
        .ctrl_out         (ctrl_out)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic        bt;
        logic [15:0] alu;
        logic [15:0] sd;
        logic [15:0] rdata;
        int          dly;
        logic [15:0] e_result;
        logic [15:0] e_addr;
        logic [1:0]  e_be;
        logic [15:0] e_wdata;
    } vec_t;

    typedef struct {
        logic [15:0]       result;
        logic [15:0]       alu;
        logic [15:0]       ir;
        logic [15:0]       pc;
        logic [CTRL_W-1:0] ctrl;
    } exp_t;

    vec_t vecs [12];
    exp_t exp_q [$];
    int   n_pass = 0;
    int   n_total = 0;
    int   pushed = 0;
    int   pulses = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [15:0] ir_of(input int i);
        return 16'h6000 + 16'(i);
    endfunction

    function automatic logic [15:0] pc_of(input int i);
        return 16'h3000 + 16'(2 * i);
    endfunction

    function automatic logic [CTRL_W-1:0] ctrl_of(input int i);
        return 24'hC0_0000 + 24'(i * 3);
    endfunction

    task automatic set_inputs(input int idx);
        valid_in      = 1'b1;
        flush         = 1'b0;
        alu_in        = vecs[idx].alu;
        store_data_in = vecs[idx].sd;
        ir_in         = ir_of(idx);
        pc_in         = pc_of(idx);
        ctrl_in       = ctrl_of(idx);
        mem_read      = vecs[idx].rd;
        mem_write     = vecs[idx].wr;
        mem_byte      = vecs[idx].bt;
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 of the cycle where the result is in MEM/WB.
    task automatic run_op(input int idx, input int nxt);
        vec_t v;
        logic m;
        int   nstall;
        exp_t e;
        v = vecs[idx];
        m = v.rd | v.wr;
        nstall = 0;
        set_inputs(idx);
        e.result = v.e_result;
        e.alu    = v.alu;
        e.ir     = ir_of(idx);
        e.pc     = pc_of(idx);
        e.ctrl   = ctrl_of(idx);
        exp_q.push_back(e);
        pushed++;
        #1;
        chk("idle_no_request", {30'b0, dmem_read, dmem_write}, 32'd0);
        chk("stall_on_accept", {31'b0, stall}, {31'b0, m});
        if (stall) nstall++;
        @(posedge clk); #1;
        if (!m) begin
            valid_in = 1'b0;
            return;
        end
        for (int k = 0; k <= v.dly; k++) begin
            if (k == v.dly) begin
                dmem_resp  = 1'b1;
                dmem_rdata = v.rdata;
                if (nxt >= 0) set_inputs(nxt);
                else valid_in = 1'b0;
            end
            #1;
            chk("dmem_read", {31'b0, dmem_read}, {31'b0, v.rd});
            chk("dmem_write", {31'b0, dmem_write}, {31'b0, v.wr & ~v.rd});
            chk("dmem_address", {16'b0, dmem_address}, {16'b0, v.e_addr});
            chk("dmem_byte_enable", {30'b0, dmem_byte_enable}, {30'b0, v.e_be});
            if (v.wr && !v.rd) chk("dmem_wdata", {16'b0, dmem_wdata}, {16'b0, v.e_wdata});
            if (stall) nstall++;
            @(posedge clk); #1;
            dmem_resp  = 1'b0;
            dmem_rdata = 16'hDEAD;
        end
        chk("stall_cycles", nstall, v.dly + 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid_out) begin
            pulses++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid_out", {31'b0, valid_out}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result_out", {16'b0, result_out}, {16'b0, e.result});
                chk("alu_out", {16'b0, alu_out}, {16'b0, e.alu});
                chk("ir_out", {16'b0, ir_out}, {16'b0, e.ir});
                chk("pc_out", {16'b0, pc_out}, {16'b0, e.pc});
                chk("ctrl_out", {8'b0, ctrl_out}, {8'b0, e.ctrl});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rd    wr    bt    alu       sd        rdata     dly result    addr      be     wdata
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000, 0, 16'h1234, 16'h0000, 2'b00, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'hBEEF, 2, 16'hBEEF, 16'h3000, 2'b11, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'h4001, 16'h00A5, 16'h0000, 0, 16'h4001, 16'h4000, 2'b10, 16'hA5A5};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h5000, 16'h0000, 16'h7F80, 1, 16'hFF80, 16'h5000, 2'b11, 16'h0000};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 16'h5001, 16'h0000, 16'h7F80, 0, 16'h007F, 16'h5000, 2'b11, 16'h0000};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h6002, 16'h1357, 16'h0000, 1, 16'h6002, 16'h6002, 2'b11, 16'h1357};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h7001, 16'h0000, 16'h2468, 1, 16'h2468, 16'h7000, 2'b11, 16'h0000};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'h8000, 16'hFFC3, 16'h0000, 0, 16'h8000, 16'h8000, 2'b01, 16'hC3C3};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h9000, 16'h5555, 16'hABCD, 1, 16'hABCD, 16'h9000, 2'b11, 16'h0000};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0000, 2'b00, 16'h0000};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 16'hA000, 16'h0000, 16'h1111, 1, 16'h1111, 16'hA000, 2'b11, 16'h0000};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 16'hA002, 16'h0000, 16'h2222, 0, 16'h2222, 16'hA002, 2'b11, 16'h0000};

        rst = 1'b1; valid_in = 1'b0; flush = 1'b0; alu_in = '0; store_data_in = '0;
        ir_in = '0; pc_in = '0; ctrl_in = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte = 1'b0; dmem_rdata = 16'hDEAD; dmem_resp = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        chk("reset_valid_out", {31'b0, valid_out}, 32'd0);
        chk("reset_result_out", {16'b0, result_out}, 32'd0);
        chk("reset_alu_out", {16'b0, alu_out}, 32'd0);
        chk("reset_ir_out", {16'b0, ir_out}, 32'd0);
        chk("reset_pc_out", {16'b0, pc_out}, 32'd0);
        chk("reset_ctrl_out", {8'b0, ctrl_out}, 32'd0);
        chk("reset_stall", {31'b0, stall}, 32'd0);
        chk("reset_dmem_req", {30'b0, dmem_read, dmem_write}, 32'd0);
        chk("reset_dmem_address", {16'b0, dmem_address}, 32'd0);
        chk("reset_dmem_be", {30'b0, dmem_byte_enable}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_op(i, -1);

        // Back-to-back loads: the second is presented in the first one's resp cycle.
        run_op(10, 11);
        run_op(11, -1);

        // Flushed store must not reach the cache or retire.
        set_inputs(5);
        flush = 1'b1;
        #1;
        chk("flush_stall", {31'b0, stall}, 32'd0);
        chk("flush_dmem_write", {31'b0, dmem_write}, 32'd0);
        @(posedge clk); #1;
        chk("flush_dmem_write_next", {31'b0, dmem_write}, 32'd0);
        chk("flush_valid_out", {31'b0, valid_out}, 32'd0);
        flush = 1'b0;
        valid_in = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of an access.
        set_inputs(1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk("pre_reset_dmem_read", {31'b0, dmem_read}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_dmem_read", {31'b0, dmem_read}, 32'd0);
        chk("async_rst_dmem_address", {16'b0, dmem_address}, 32'd0);
        chk("async_rst_stall", {31'b0, stall}, 32'd0);
        chk("async_rst_valid_out", {31'b0, valid_out}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_idle", {30'b0, dmem_read, dmem_write}, 32'd0);

        run_op(0, -1);
        run_op(3, -1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        chk("valid_out_pulses", pulses, pushed);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
